// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared widths, limits and types for the snake score tracker.
//  Revision    : 1.0  initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W   = 7;
    localparam int MAX_SCORE = 99;

    typedef logic [SCORE_W-1:0] score_t;

endpackage : score_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : One-cycle rising-edge detector for a level input.
//  Revision    : 1.0  initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic rise
);

    logic r_d_q;

    // Remember last cycle's level; history clears on reset.
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= d;
        end
    end

    assign rise = d & ~r_d_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/stop_watch_score.sv
`default_nettype none
// ============================================================================
//  Module      : stop_watch_score
//  Description : Snake-game score tracker. Counts apples, holds the best
//                score since reset, and flags game over on a loss or win.
//  Revision    : 1.0  initial release
// ============================================================================
module stop_watch_score
    import score_pkg::*;
#(
    parameter int SCORE_W   = score_pkg::SCORE_W,
    parameter int MAX_SCORE = score_pkg::MAX_SCORE
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               goodColl,
    input  logic               badColl,
    output logic [SCORE_W-1:0] currScore,
    output logic [SCORE_W-1:0] highScore,
    output logic               isGameComplete
);

    localparam logic [SCORE_W-1:0] c_max_score = SCORE_W'(MAX_SCORE);

    logic               w_good_rise;
    logic [SCORE_W-1:0] w_score_inc;
    logic [SCORE_W-1:0] w_next_score;
    logic               w_next_done;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic               r_done;

    rise_detect u_good_rise (
        .clk  (clk),
        .nRst (nRst),
        .d    (goodColl),
        .rise (w_good_rise)
    );

    assign w_score_inc = r_score + 1'b1;

    // Next score / game-over state: a loss outranks an apple on the same edge;
    // after game over only an apple matters, and it restarts without scoring.
    always_comb begin
        w_next_score = r_score;
        w_next_done  = r_done;
        if (!r_done) begin
            if (badColl) begin
                w_next_done = 1'b1;
            end else if (w_good_rise) begin
                w_next_score = w_score_inc;
                if (w_score_inc == c_max_score) begin
                    w_next_done = 1'b1;
                end
            end
        end else if (w_good_rise) begin
            w_next_score = '0;
            w_next_done  = 1'b0;
        end
    end

    // Score, best score and game-over flag registers. Best score tracks the
    // next current score so it moves on the same edge as the counter.
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_score <= '0;
            r_high  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_score <= w_next_score;
            r_done  <= w_next_done;
            if (w_next_score > r_high) begin
                r_high <= w_next_score;
            end
        end
    end

    assign currScore      = r_score;
    assign highScore      = r_high;
    assign isGameComplete = r_done;

endmodule : stop_watch_score
`default_nettype wire

// File: tb/tb_stop_watch_score.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stop_watch_score
//  Description : Scoreboard bench for stop_watch_score with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stop_watch_score;

    logic       clk;
    logic       nRst;
    logic       goodColl;
    logic       badColl;
    logic [6:0] currScore;
    logic [6:0] highScore;
    logic       isGameComplete;

    int total = 0;
    int bad   = 0;

    string      q_name[$];
    logic [6:0] q_score[$];
    logic [6:0] q_high[$];
    logic       q_done[$];

    stop_watch_score dut (
        .clk            (clk),
        .nRst           (nRst),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .currScore      (currScore),
        .highScore      (highScore),
        .isGameComplete (isGameComplete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, return just after the rise.
    task automatic cyc(input logic g, input logic b, input logic r);
        @(negedge clk);
        goodColl = g;
        badColl  = b;
        nRst     = r;
        @(posedge clk);
        #1;
    endtask

    // Queue the outputs expected after the edge just taken.
    task automatic expect_out(input string name, input int s, input int h, input logic d);
        q_name.push_back(name);
        q_score.push_back(7'(s));
        q_high.push_back(7'(h));
        q_done.push_back(d);
    endtask

    task automatic pulse();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: on each falling edge drain queued expectations against the DUT.
    initial begin
        string      n;
        logic [6:0] es;
        logic [6:0] eh;
        logic       ed;
        forever begin
            @(negedge clk);
            while (q_name.size() > 0) begin
                n  = q_name.pop_front();
                es = q_score.pop_front();
                eh = q_high.pop_front();
                ed = q_done.pop_front();
                total++;
                if (currScore !== es) begin
                    bad++;
                    $display("FAIL %s currScore got=%0d want=%0d", n, currScore, es);
                end
                total++;
                if (highScore !== eh) begin
                    bad++;
                    $display("FAIL %s highScore got=%0d want=%0d", n, highScore, eh);
                end
                total++;
                if (isGameComplete !== ed) begin
                    bad++;
                    $display("FAIL %s isGameComplete got=%0d want=%0d", n, isGameComplete, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        goodColl = 1'b0;
        badColl  = 1'b0;
        nRst     = 1'b1;

        // 1. Reset dominates noisy inputs.
        cyc(1'b1, 1'b1, 1'b1);
        expect_out("reset_c1", 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        expect_out("reset_c2", 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        expect_out("post_reset", 0, 0, 1'b0);

        // 2. A held level counts exactly once.
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("first_apple", 1, 1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
        expect_out("held_high", 1, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // 3. Up to 5, lose, restart without scoring.
        for (int i = 0; i < 4; i++) pulse();
        expect_out("five", 5, 5, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("loss", 5, 5, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("bad_ignored", 5, 5, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("restart", 0, 5, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // 4. Best score held until beaten.
        for (int i = 0; i < 3; i++) pulse();
        expect_out("three", 3, 5, 1'b0);
        for (int i = 0; i < 3; i++) pulse();
        expect_out("six", 6, 6, 1'b0);

        // 5. Simultaneous apple and loss: loss wins.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("restart2", 0, 6, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        pulse();
        pulse();
        expect_out("two", 2, 6, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        expect_out("same_edge", 2, 6, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        expect_out("same_edge_hold", 2, 6, 1'b1);

        // 6. Win at 99, then mid-game reset.
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("restart3", 0, 6, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 98; i++) begin
            pulse();
            if (i % 10 == 0) expect_out("climb", i, (i > 6) ? i : 6, 1'b0);
        end
        expect_out("ninety_eight", 98, 98, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("win", 99, 99, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("win_bad_ignored", 99, 99, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("restart4", 0, 99, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) pulse();
        expect_out("forty", 40, 99, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        expect_out("mid_reset", 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        pulse();
        expect_out("after_reset_apple", 1, 1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q_name.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q_name.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stop_watch_score
`default_nettype wire
